divider_seq_param: RTL and testbench

DIVIDER_SEQ_PARAM -- requirements
Module: divider_seq_param

---
 rtl/divider_seq_param.sv | 141 ++++++++++++++
 tb/tb_divider_seq_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_param.sv
// Sequential restoring divider, signed or unsigned, fixed latency of BITSIZE+2 edges per operation.
// Divide-by-zero returns all-ones quotient and the untouched dividend as remainder.
module divider_seq_param #(
  parameter int unsigned BITSIZE   = 16,
  parameter int unsigned INDEXSIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               strt,
  input  logic               sgn,
  input  logic [BITSIZE-1:0] dividend,
  input  logic [BITSIZE-1:0] divisor,
  output logic [BITSIZE-1:0] quotient,
  output logic [BITSIZE-1:0] remainder,
  output logic               not_valid,
  output logic               done,
  output logic               idle
);

  localparam int unsigned W = BITSIZE;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         dvd_q, dvd_d;        // original dividend, returned on divide-by-zero
  logic [W-1:0]         mag_d_q, mag_d_d;    // divisor magnitude
  logic [W-1:0]         quo_acc_q, quo_acc_d;
  logic [W-1:0]         rem_acc_q, rem_acc_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 dz_q, dz_d;
  logic [INDEXSIZE-1:0] idx_q, idx_d;
  logic [W-1:0]         quotient_q, quotient_d;
  logic [W-1:0]         remainder_q, remainder_d;
  logic                 not_valid_q, not_valid_d;
  logic                 done_q, done_d;
  logic [W:0]           trial;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    mag_d_d     = mag_d_q;
    quo_acc_d   = quo_acc_q;
    rem_acc_d   = rem_acc_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    dz_d        = dz_q;
    idx_d       = idx_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    not_valid_d = not_valid_q;
    done_d      = 1'b0;
    // Quotient accumulator doubles as the dividend shift register: its MSB feeds the remainder.
    trial       = {rem_acc_q, quo_acc_q[W-1]} - {1'b0, mag_d_q};

    unique case (state_q)
      StIdle: begin
        if (strt) begin
          state_d   = StCalc;
          dvd_d     = dividend;
          dz_d      = (divisor == '0);
          neg_q_d   = sgn & (dividend[W-1] ^ divisor[W-1]);
          neg_r_d   = sgn & dividend[W-1];
          quo_acc_d = (sgn && dividend[W-1]) ? -dividend : dividend;
          mag_d_d   = (sgn && divisor[W-1]) ? -divisor : divisor;
          rem_acc_d = '0;
          idx_d     = INDEXSIZE'(W - 1);
        end
      end
      StCalc: begin
        if (!trial[W]) begin
          rem_acc_d = trial[W-1:0];
          quo_acc_d = {quo_acc_q[W-2:0], 1'b1};
        end else begin
          rem_acc_d = {rem_acc_q[W-2:0], quo_acc_q[W-1]};
          quo_acc_d = {quo_acc_q[W-2:0], 1'b0};
        end
        if (idx_q == '0) begin
          state_d = StFix;
        end else begin
          idx_d = idx_q - INDEXSIZE'(1);
        end
      end
      StFix: begin
        state_d     = StDone;
        done_d      = 1'b1;
        not_valid_d = dz_q;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = neg_q_q ? -quo_acc_q : quo_acc_q;
          remainder_d = neg_r_q ? -rem_acc_q : rem_acc_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      mag_d_q     <= '0;
      quo_acc_q   <= '0;
      rem_acc_q   <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dz_q        <= 1'b0;
      idx_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      not_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      mag_d_q     <= mag_d_d;
      quo_acc_q   <= quo_acc_d;
      rem_acc_q   <= rem_acc_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      dz_q        <= dz_d;
      idx_q       <= idx_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      not_valid_q <= not_valid_d;
      done_q      <= done_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign not_valid = not_valid_q;
  assign done      = done_q;
  assign idle      = (state_q == StIdle);

endmodule

// File: tb/tb_divider_seq_param.sv
// Directed and randomized checks of divider_seq_param with a 16-bit and an 8-bit instance.
module tb_divider_seq_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        strt16, sgn16, nv16, done16, idle16;
  logic [15:0] a16, b16, q16, r16;
  logic        strt8, sgn8, nv8, done8, idle8;
  logic [7:0]  a8, b8, q8, r8;

  int checks   = 0;
  int failures = 0;

  divider_seq_param #(.BITSIZE(16), .INDEXSIZE(4)) u_dut16 (
    .clk(clk), .rst(rst), .strt(strt16), .sgn(sgn16), .dividend(a16), .divisor(b16),
    .quotient(q16), .remainder(r16), .not_valid(nv16), .done(done16), .idle(idle16)
  );

  divider_seq_param #(.BITSIZE(8), .INDEXSIZE(3)) u_dut8 (
    .clk(clk), .rst(rst), .strt(strt8), .sgn(sgn8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .not_valid(nv8), .done(done8), .idle(idle8)
  );

  // Runs one 16-bit operation; operands are scrambled right after the accept edge.
  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] q, output logic [15:0] r, output logic nv,
                      output int lat, output logic idle_ok, output logic done_after);
    @(negedge clk);
    sgn16 = s; a16 = a; b16 = b; strt16 = 1'b1;
    @(posedge clk); #1;
    strt16 = 1'b0; sgn16 = ~s; a16 = ~a; b16 = 16'h0003;
    lat = 0;
    idle_ok = (idle16 === 1'b0);
    while (done16 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat <= 17 && idle16 !== 1'b0) idle_ok = 1'b0;
    end
    q = q16; r = r16; nv = nv16;
    @(posedge clk); #1;
    done_after = done16;
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r, output logic nv, output int lat);
    @(negedge clk);
    sgn8 = s; a8 = a; b8 = b; strt8 = 1'b1;
    @(posedge clk); #1;
    strt8 = 1'b0; a8 = ~a; b8 = 8'h05;
    lat = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    q = q8; r = r8; nv = nv8;
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, qi, ri;
    if (b == 8'd0) return {8'hFF, a, 1'b1};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -128 && sb == -1) return {8'h80, 8'h00, 1'b0};
      qi = sa / sb;
      ri = sa % sb;
    end else begin
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
    end
    return {qi[7:0], ri[7:0], 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    strt16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    strt8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    checks++; if (q16 !== 16'h0) begin failures++; $display("FAIL reset_q got=%h exp=0000", q16); end
    checks++; if (r16 !== 16'h0) begin failures++; $display("FAIL reset_r got=%h exp=0000", r16); end
    checks++; if (nv16 !== 1'b0) begin failures++; $display("FAIL reset_nv got=%b exp=0", nv16); end
    checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done16); end
    checks++; if (idle16 !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle16); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [15:0] q, r;
    logic nv, idle_ok, done_after;
    int lat;
    op16(1'b0, 16'd1000, 16'd7, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'd142) begin failures++; $display("FAIL u1000_7_q got=%0d exp=142", q); end
    checks++; if (r !== 16'd6) begin failures++; $display("FAIL u1000_7_r got=%0d exp=6", r); end
    checks++; if (nv !== 1'b0) begin failures++; $display("FAIL u1000_7_nv got=%b exp=0", nv); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL u1000_7_latency got=%0d exp=17", lat); end
    checks++; if (idle_ok !== 1'b1) begin failures++; $display("FAIL u1000_7_idle_low got=%b exp=1", idle_ok); end
    checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done_after); end
    checks++; if (idle16 !== 1'b1) begin failures++; $display("FAIL idle_return got=%b exp=1", idle16); end
    // Results must hold while inputs wander with strt low.
    repeat (5) begin
      @(negedge clk);
      a16 = 16'hBEEF; b16 = 16'h0000; sgn16 = 1'b1;
    end
    #1;
    checks++; if (q16 !== 16'd142 || r16 !== 16'd6) begin
      failures++; $display("FAIL hold got=%0d/%0d exp=142/6", q16, r16);
    end
    op16(1'b0, 16'hFFFF, 16'd1, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'hFFFF || r !== 16'h0) begin
      failures++; $display("FAIL uFFFF_1 got=%h/%h exp=ffff/0000", q, r);
    end
  endtask

  task automatic test_signed();
    logic [15:0] q, r;
    logic nv, idle_ok, done_after;
    int lat;
    op16(1'b1, 16'hFFF9, 16'd2, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'hFFFD || r !== 16'hFFFF) begin
      failures++; $display("FAIL s_m7_2 got=%h/%h exp=fffd/ffff", q, r);
    end
    op16(1'b1, 16'd7, 16'hFFFE, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'hFFFD || r !== 16'h0001) begin
      failures++; $display("FAIL s_7_m2 got=%h/%h exp=fffd/0001", q, r);
    end
    op16(1'b1, 16'hFFF9, 16'hFFFE, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'h0003 || r !== 16'hFFFF) begin
      failures++; $display("FAIL s_m7_m2 got=%h/%h exp=0003/ffff", q, r);
    end
    op16(1'b1, 16'h8000, 16'hFFFF, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'h8000 || r !== 16'h0000 || nv !== 1'b0) begin
      failures++; $display("FAIL s_overflow got=%h/%h/%b exp=8000/0000/0", q, r, nv);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r;
    logic nv, idle_ok, done_after;
    int lat;
    for (int s = 0; s < 2; s++) begin
      op16(s[0], 16'h1234, 16'h0000, q, r, nv, lat, idle_ok, done_after);
      checks++; if (q !== 16'hFFFF || r !== 16'h1234 || nv !== 1'b1) begin
        failures++; $display("FAIL div0_sgn%0d got=%h/%h/%b exp=ffff/1234/1", s, q, r, nv);
      end
      checks++; if (lat !== 17) begin
        failures++; $display("FAIL div0_latency_sgn%0d got=%0d exp=17", s, lat);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] q, r;
    logic nv, idle_ok, done_after, seen;
    int lat;
    @(negedge clk);
    sgn16 = 1'b0; a16 = 16'd1000; b16 = 16'd7; strt16 = 1'b1;
    @(posedge clk); #1;
    strt16 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (q16 !== 16'h0 || r16 !== 16'h0 || nv16 !== 1'b0 || done16 !== 1'b0) begin
      failures++; $display("FAIL abort_clear got=%h/%h/%b/%b exp=0000/0000/0/0", q16, r16, nv16, done16);
    end
    checks++; if (idle16 !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", idle16); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done16 === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    op16(1'b0, 16'd100, 16'd9, q, r, nv, lat, idle_ok, done_after);
    checks++; if (q !== 16'd11 || r !== 16'd1) begin
      failures++; $display("FAIL after_abort got=%0d/%0d exp=11/1", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [7:0] q1, r1, q2, r2;
    d1 = -1; d2 = -1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    @(negedge clk);
    sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd7; strt8 = 1'b1;
    @(posedge clk); #1;
    sgn8 = 1'b1; a8 = 8'h9C; b8 = 8'd7;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        if (d1 < 0) begin
          d1 = e; q1 = q8; r1 = r8;
        end else if (d2 < 0) begin
          d2 = e; q2 = q8; r2 = r8;
        end
      end
      if (e == 13) begin sgn8 = 1'b0; a8 = 8'd1; b8 = 8'd1; end
      if (e == 20) strt8 = 1'b0;
    end
    checks++; if (d1 !== 9) begin failures++; $display("FAIL b2b_first_done got=%0d exp=9", d1); end
    checks++; if (d2 - d1 !== 11) begin failures++; $display("FAIL b2b_period got=%0d exp=11", d2 - d1); end
    checks++; if (q1 !== 8'd28 || r1 !== 8'd4) begin
      failures++; $display("FAIL b2b_op1 got=%0d/%0d exp=28/4", q1, r1);
    end
    checks++; if (q2 !== 8'hF2 || r2 !== 8'hFE) begin
      failures++; $display("FAIL b2b_op2 got=%h/%h exp=f2/fe", q2, r2);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, q, r;
    logic s, nv;
    logic [16:0] exp;
    int lat;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      if (i % 50 == 7) b = 8'h00;
      if (i % 97 == 3) begin a = 8'h80; b = 8'hFF; s = 1'b1; end
      exp = ref8(s, a, b);
      op8(s, a, b, q, r, nv, lat);
      checks++; if ({q, r, nv} !== exp || lat !== 9) begin
        failures++;
        $display("FAIL rand_%0d s=%b a=%h b=%h got=%h/%h/%b lat=%0d exp=%h/%h/%b lat=9",
                 i, s, a, b, q, r, nv, lat, exp[16:9], exp[8:1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
